// File: rtl/leaf_loopback_tester.sv
// BFT-side stimulus/check engine for a leaf page: sends numbered LFSR packets
// with a resend strobe, compares the page's echo and tallies mismatches.
module leaf_loopback_tester #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_pkts,
  input  logic [4:0]  dst_leaf,
  input  logic [3:0]  dst_port,
  input  logic [31:0] seed,
  output logic [48:0] dout_leaf_bft2interface,
  output logic        resend,
  input  logic [48:0] din_leaf_interface2bft,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_idx
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] num_q, num_d;
  logic [4:0]  leaf_q, leaf_d;
  logic [3:0]  port_q, port_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [48:0] dout_q, dout_d;
  logic        resend_q, resend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] err_q, err_d;
  logic [15:0] fe_q, fe_d;

  logic        is_last;
  logic        mismatch;
  logic [31:0] seed_eff;
  logic [4:0]  pkt_leaf;
  logic [3:0]  pkt_port;
  logic [31:0] pkt_payload;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  assign is_last  = (idx_q == num_q - 16'd1);
  assign mismatch = (din_leaf_interface2bft != dout_q);
  assign seed_eff = (seed == 32'd0) ? 32'd1 : seed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_pkts == 16'd0) ? S_DONE : S_SEND;
      S_SEND:  state_d = (LAT > 1) ? S_WAIT : S_CHECK;
      S_WAIT:  if (wait_q == 4'(LAT - 1)) state_d = S_CHECK;
      S_CHECK: state_d = is_last ? S_DONE : S_SEND;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wait_d   = wait_q;
    idx_d    = idx_q;
    num_d    = num_q;
    leaf_d   = leaf_q;
    port_d   = port_q;
    lfsr_d   = lfsr_q;
    dout_d   = dout_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fe_d     = fe_q;

    if (state_q == S_SEND)      wait_d = 4'd1;
    else if (state_q == S_WAIT) wait_d = wait_q + 4'd1;

    if (state_q == S_IDLE && start) begin
      num_d  = num_pkts;
      leaf_d = dst_leaf;
      port_d = dst_port;
      lfsr_d = seed_eff;
      idx_d  = 16'd0;
      err_d  = 16'd0;
      fe_d   = 16'hFFFF;
      pass_d = 1'b0;
    end

    if (state_q == S_CHECK) begin
      if (mismatch) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0)    fe_d  = idx_q;
      end
      if (!is_last) idx_d = idx_q + 16'd1;
    end

    // The first packet is built straight from the start-cycle inputs.
    pkt_leaf    = (state_q == S_IDLE) ? dst_leaf : leaf_q;
    pkt_port    = (state_q == S_IDLE) ? dst_port : port_q;
    pkt_payload = (state_q == S_IDLE) ? seed_eff : lfsr_q;

    if (state_d == S_SEND) begin
      dout_d = {1'b1, pkt_leaf, pkt_port, idx_d[6:0], pkt_payload};
      lfsr_d = lfsr_next(pkt_payload);
    end else if (state_d == S_DONE || state_d == S_IDLE) begin
      dout_d = 49'd0;
    end

    resend_d = (state_d == S_SEND);
    busy_d   = (state_d == S_SEND) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d   = (state_d == S_DONE);
    if (state_d == S_DONE) pass_d = (err_d == 16'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q   <= 4'd0;
      idx_q    <= 16'd0;
      num_q    <= 16'd0;
      leaf_q   <= 5'd0;
      port_q   <= 4'd0;
      lfsr_q   <= 32'd1;
      dout_q   <= 49'd0;
      resend_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 16'd0;
      fe_q     <= 16'hFFFF;
    end else begin
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      leaf_q   <= leaf_d;
      port_q   <= port_d;
      lfsr_q   <= lfsr_d;
      dout_q   <= dout_d;
      resend_q <= resend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fe_q     <= fe_d;
    end
  end

  assign dout_leaf_bft2interface = dout_q;
  assign resend                  = resend_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign pass                    = pass_q;
  assign err_count               = err_q;
  assign first_err_idx           = fe_q;

endmodule
